serial_pattern_tx: RTL and testbench



---
 rtl/serial_pattern_tx_if.sv | 30 +++
 rtl/serial_pattern_tx.sv | 131 +++++++++++++
 tb/tb_serial_pattern_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/serial_pattern_tx_if.sv
// Word handshake and serial output bundle for serial_pattern_tx.
// The master drives words in, and the slave (the transmitter) drives the serial stream out.
interface serial_pattern_tx_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             dout;
    logic             busy;
    logic             last;

    modport master (
        output din,
        output load,
        input  ready,
        input  dout,
        input  busy,
        input  last
    );

    modport slave (
        input  din,
        input  load,
        output ready,
        output dout,
        output busy,
        output last
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// LSB-first parallel-to-serial transmitter with gapless back-to-back words.
// Define SERIAL_TX_PARITY_EN to append one even-parity bit after each word's MSB.
//
// state  | meaning
// IDLE   | no word in flight; ready for a load
// SHIFT  | data bit cnt of the current word is on dout
// PARITY | even parity of the word is on dout (SERIAL_TX_PARITY_EN only)
module serial_pattern_tx #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_pattern_tx_if.slave    link
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d      = par_q;
`endif
        link.ready = 1'b0;
        link.dout  = 1'b0;
        link.busy  = 1'b0;
        link.last  = 1'b0;

        case (state_q)
            IDLE: begin
                link.ready = 1'b1;
                if (link.load) begin
                    sh_d    = link.din;
                    cnt_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = 1'b0;
`endif
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                link.dout = sh_q[0];
                link.busy = 1'b1;
                sh_d      = sh_q >> 1;
                cnt_d     = cnt_q + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                par_d     = par_q ^ sh_q[0];
                if (cnt_q == CNT_LAST) begin
                    state_d = PARITY;
                end
`else
                if (cnt_q == CNT_LAST) begin
                    link.last  = 1'b1;
                    link.ready = 1'b1;
                    // Reloading here keeps the stream gapless across words.
                    if (link.load) begin
                        sh_d    = link.din;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
`endif
            end

`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                link.dout  = par_q;
                link.busy  = 1'b1;
                link.last  = 1'b1;
                link.ready = 1'b1;
                if (link.load) begin
                    sh_d    = link.din;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: word framing, gapless streaming, ignored loads,
// mid-word reset and (with SERIAL_TX_PARITY_EN) the parity bit.
module tb_serial_pattern_tx;

    localparam int WIDTH = 16;
`ifdef SERIAL_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    serial_pattern_tx_if #(.WIDTH(WIDTH)) bus ();

    serial_pattern_tx #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " dout"},  32'(bus.dout),  32'd0);
        chk({tag, " busy"},  32'(bus.busy),  32'd0);
        chk({tag, " last"},  32'(bus.last),  32'd0);
        chk({tag, " ready"}, 32'(bus.ready), 32'd1);
    endtask

    // Call right after the edge that accepted w. Checks every bit of the word.
    // chain: load nw in the word's last cycle. ign_k: drive an illegal load of
    // 16'hFFFF during data bit ign_k (-1 for none).
    task automatic run_word(input string tag, input logic [15:0] w, input bit chain,
                            input logic [15:0] nw, input int ign_k);
        for (int k = 0; k < WIDTH; k++) begin
            logic is_last;
            is_last = (k == WIDTH - 1) && !PAR;
            chk($sformatf("%s bit%0d dout", tag, k),  32'(bus.dout),  32'(w[k]));
            chk($sformatf("%s bit%0d busy", tag, k),  32'(bus.busy),  32'd1);
            chk($sformatf("%s bit%0d last", tag, k),  32'(bus.last),  32'(is_last));
            chk($sformatf("%s bit%0d ready", tag, k), 32'(bus.ready), 32'(is_last));
            if (k == ign_k) begin
                bus.load = 1'b1;
                bus.din  = 16'hFFFF;
            end
            if (is_last && chain) begin
                bus.load = 1'b1;
                bus.din  = nw;
            end
            tick();
            bus.load = 1'b0;
            bus.din  = 16'h0000;
        end
        if (PAR) begin
            chk($sformatf("%s parity dout", tag), 32'(bus.dout),  32'(^w));
            chk($sformatf("%s parity busy", tag), 32'(bus.busy),  32'd1);
            chk($sformatf("%s parity last", tag), 32'(bus.last),  32'd1);
            chk($sformatf("%s parity ready", tag), 32'(bus.ready), 32'd1);
            if (chain) begin
                bus.load = 1'b1;
                bus.din  = nw;
            end
            tick();
            bus.load = 1'b0;
            bus.din  = 16'h0000;
        end
    endtask

    task automatic start_word(input logic [15:0] w);
        bus.load = 1'b1;
        bus.din  = w;
        tick();
        bus.load = 1'b0;
        bus.din  = 16'h0000;
    endtask

    initial begin
        bus.din  = 16'h0000;
        bus.load = 1'b1;       // reset must win over load
        rst      = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        bus.load = 1'b0;
        chk_idle("reset");

        // Single word 16'hAAAA: 0,1,0,1,...
        start_word(16'hAAAA);
        run_word("aaaa", 16'hAAAA, 1'b0, 16'h0000, -1);
        chk_idle("after_aaaa");

        // Gapless 16'h5555 then 16'h3B56 loaded in the last cycle.
        start_word(16'h5555);
        run_word("s5555", 16'h5555, 1'b1, 16'h3B56, -1);
        run_word("s3b56", 16'h3B56, 1'b0, 16'h0000, -1);
        chk_idle("after_stream");

        // 16'hFFFF offered at bit 5 of a 16'h0000 word is ignored.
        start_word(16'h0000);
        run_word("ign", 16'h0000, 1'b0, 16'h0000, 5);
        chk_idle("after_ign");
        tick();
        chk_idle("ign_no_ffff");

        // Reset while bit 5 of 16'hFFFF is on dout.
        start_word(16'hFFFF);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rstmid bit%0d dout", k), 32'(bus.dout), 32'd1);
            tick();
        end
        chk("rstmid bit5 dout", 32'(bus.dout), 32'd1);
        chk("rstmid bit5 busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rstmid_after");
        tick();
        chk_idle("rstmid_hold");
        start_word(16'h0001);
        run_word("post_rst", 16'h0001, 1'b0, 16'h0000, -1);
        chk_idle("after_post_rst");

        // Parity cases: 16'h0001 -> parity 1, 16'h0003 -> parity 0.
        start_word(16'h0001);
        run_word("p0001", 16'h0001, 1'b0, 16'h0000, -1);
        chk_idle("after_p0001");
        start_word(16'h0003);
        run_word("p0003", 16'h0003, 1'b0, 16'h0000, -1);
        chk_idle("after_p0003");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
